// File: rtl/tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the shared serial transmitter arbiter.
// slave = arbiter, master = requesters plus transmitter observers.
interface tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Handshake: requester i raises req_valid[i] with its word on req_data[7i+6:7i] and holds it
    // until req_ready[i] pulses for one cycle; the word is taken on the edge that raises req_ready[i].
    // Withdrawing req_valid before that edge is legal. tx_start pulses once per accepted word.
    logic [NUM_REQ-1:0]   req_valid;
    logic [7*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [6:0]           tx_data;
    logic [ID_W-1:0]      grant_id;
    logic                 busy;
    logic                 frame_done;

    modport master (
        output req_valid, req_data,
        input  req_ready, tx_start, tx_data, grant_id, busy, frame_done
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, tx_start, tx_data, grant_id, busy, frame_done
    );
endinterface

// File: rtl/tx_arbiter.sv
// Round-robin owner of a 7-bit serial transmitter: grants one word per frame, holds tx_data
// for the whole frame and enforces a guard gap (and a post-reset cooldown) between starts.
module tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int FRAME_CYCLES = 9,
    parameter int GUARD_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    tx_arbiter_if.slave  bus,
    output logic [1:0]   dbg_state
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(FRAME_CYCLES + GUARD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FRAME_CYCLES + GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        COOLDOWN = 2'd0,
        IDLE     = 2'd1,
        RUN      = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic               tx_start_q, tx_start_d;
    logic [6:0]         tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;

    logic               win_found;
    logic [ID_W-1:0]    win_idx;
    logic [6:0]         win_word;
    logic               grant;
    int                 idx;

    // Search starts just after the last winner, so the last winner has lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_word  = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_found && bus.req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(idx);
                win_word  = bus.req_data[7*idx +: 7];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        tx_start_d   = 1'b0;
        req_ready_d  = '0;
        tx_data_d    = tx_data_q;
        grant_id_d   = grant_id_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        grant        = 1'b0;

        case (state_q)
            COOLDOWN: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            IDLE: begin
                busy_d = 1'b0;
                grant  = win_found;
            end
            RUN: begin
                // Guard end doubles as an arbitration slot so back-to-back frames stay gap-exact.
                if (cnt_q == '0) begin
                    state_d      = IDLE;
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                    grant        = win_found;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = COOLDOWN;
        endcase

        if (grant) begin
            state_d     = RUN;
            cnt_d       = CNT_INIT;
            ptr_d       = win_idx;
            tx_start_d  = 1'b1;
            req_ready_d = NUM_REQ'(1) << win_idx;
            tx_data_d   = win_word;
            grant_id_d  = win_idx;
            busy_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= COOLDOWN;
            cnt_q        <= CNT_INIT;
            ptr_q        <= ID_W'(NUM_REQ - 1);
            tx_start_q   <= 1'b0;
            req_ready_q  <= '0;
            tx_data_q    <= '0;
            grant_id_q   <= '0;
            busy_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            tx_start_q   <= tx_start_d;
            req_ready_q  <= req_ready_d;
            tx_data_q    <= tx_data_d;
            grant_id_q   <= grant_id_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.tx_start   = tx_start_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.grant_id   = grant_id_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign dbg_state      = state_q;
endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Round-robin controller that shares one 7-bit serial transmitter (start bit, 7 data bits LSB first, even/odd parity bit from XOR of data) among NUM_REQ requesters. It accepts one word at a time from a requester, drives the transmitter's `start` pulse and holds `data_in` stable for the whole frame. It enforces an idle guard interval between frames so the transmitter returns to idle before the next start. It sits between the client logic and the transmitter and is the only agent allowed to drive the transmitter's `start` and `data_in`.

## Interface
- NUM_REQ, 4: number of requesters, ≥2.
- FRAME_CYCLES, 9: transmitter edges from `start` sample to parity bit inclusive (start bit + 7 data + parity).
- GUARD_CYCLES, 1: minimum idle-high cycles on the line between frames, ≥1.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request; held until matching `req_ready`.
- req_data  in  7*NUM_REQ  requester i's word at bits [7i+6:7i].
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse; word sampled on that edge.
- tx_start  out  1  one-cycle start pulse to transmitter.
- tx_data  out  7  word to transmitter `data_in`.
- grant_id  out  max(1,clog2(NUM_REQ))  index of requester owning current/last frame.
- busy  out  1  high while a frame, guard or post-reset cooldown is in progress.
- frame_done  out  1  one-cycle pulse when a frame's guard interval ends.

## Operation
- States: COOLDOWN, IDLE, RUN. All outputs registered.
- Reset: state COOLDOWN, counter = FRAME_CYCLES+GUARD_CYCLES−1, rr pointer = NUM_REQ−1 (requester 0 highest priority), tx_start 0, tx_data 0, req_ready 0, grant_id 0, frame_done 0, busy 1.
- COOLDOWN: no grants; counter decrements each cycle; at 0 -> IDLE, busy 0. No frame_done. Protects a frame in flight at reset time (transmitter has its own reset).
- IDLE: if any req_valid, winner = first valid index searching pointer+1, pointer+2, … modulo NUM_REQ. On that edge: tx_data <= winner's word, req_ready[winner] <= 1, tx_start <= 1, grant_id <= winner, pointer <= winner, busy <= 1, counter <= FRAME_CYCLES+GUARD_CYCLES−1, -> RUN. No valid: outputs hold, busy 0.
- RUN: tx_start and req_ready return to 0 after one cycle; tx_data held unchanged; counter decrements; at counter 0 -> IDLE, frame_done pulse 1 cycle, busy 0.
- Counter width: clog2(FRAME_CYCLES+GUARD_CYCLES+1).
- req_valid deassertion before grant is legal (request withdrawn). Changes to req_data of non-granted requesters never affect tx_data.
- tx_data is never changed except at a grant edge (transmitter reads data bits and parity combinationally/late from it).

## Timing
- Grant edge E0: tx_start high E0→E1; transmitter start bit from E1, data E2..E8, parity E9, line idle from E10.
- IDLE re-entered at edge E0+FRAME_CYCLES+GUARD_CYCLES (E10 default) with frame_done high for that cycle. Earliest next grant also at E10, so back-to-back start-to-start spacing is exactly FRAME_CYCLES+GUARD_CYCLES = 10 edges; next start bit at E11 gives exactly GUARD_CYCLES idle cycle.
- frame_done and a new grant coincide in the same cycle when a request is pending (frame_done, tx_start, busy all high).
- Request-to-accept latency from IDLE: 1 edge (req_valid high before edge E0 -> req_ready high after E0).
- Requests arriving during RUN/COOLDOWN wait; no queueing beyond the requester's own hold.
- rst asserted mid-RUN: next edge forces reset values, any pending req_ready/tx_start dropped; granted word is not re-sent; cooldown of FRAME_CYCLES+GUARD_CYCLES cycles before first new grant.

## Test plan
- Reset release, req_valid=0001 held, req_data[6:0]=7'h55: no tx_start for 10 cycles (busy 1), then grant: req_ready=0001, tx_start 1 cycle, tx_data=7'h55, grant_id 0.
- Single request 7'h2A from requester 2 in IDLE: tx_data=7'h2A for ≥10 cycles, frame_done pulse 10 edges after grant, attached transmitter emits 0, bits 0,1,0,1,0,1,0, parity 1, then 1.
- All four requesting continuously, distinct words: grant order 0,1,2,3,0, tx_start pulses exactly 10 cycles apart, each req_ready exactly once per grant.
- Requesters 1 and 3 only, pointer at 1: next grant 3, then 1; requester 3 withdrawing before grant -> grant goes to 1.
- rst pulsed 4 cycles into a frame: outputs return to reset values, busy 1 for 10 cycles after release, no tx_start during cooldown, previous word not resent.
- Requester word changed while another frame in RUN: tx_data unchanged until next grant edge.
